// File: rtl/video_timing_gen.sv
// -----------------------------------------------------------------------------
// video_timing_gen
//
// Programmable video raster generator. Two counters walk the raster
// (h_cnt across a line, v_cnt down the frame). Every line is laid out as
// active, front porch, sync, back porch, and the frame uses the same order
// counted in lines. Sync, data-enable, pixel coordinates, a test pattern and
// a frame-start strobe are decoded from the counters and registered, so every
// output lags the counter state it describes by one clock.
//
// Run control: en_i starts the raster from pixel (0,0). Dropping en_i lets
// the current frame finish before the outputs return to idle. Raising en_i
// again before that frame ends resumes with no gap.
//
// Optional feature (macro VTG_BORDER_EN): when defined, the outermost active
// rows and columns are forced to white on top of whatever pattern is selected.
// When undefined, data_o carries the pattern only.
//
// Ports:
//   clk_i          pixel clock
//   rst_i          synchronous active-high reset
//   en_i           run request, level-sensitive
//   mode_i         pattern: 0 black, 1 colour bars, 2 gradient, 3 checkerboard
//   hsync_o        horizontal sync, active level HS_POL
//   vsync_o        vertical sync, active level VS_POL
//   de_o           active-video enable
//   data_o         pixel {R,G,B}, R in the MSBs, COLOR_W bits per channel
//   x_o            active pixel column (0 outside active video)
//   y_o            active line (0 outside active video)
//   frame_start_o  one-cycle pulse on the output cycle of pixel (0,0)
// -----------------------------------------------------------------------------
module video_timing_gen #(
    parameter int   H_ACTIVE   = 1920,
    parameter int   H_FP       = 88,
    parameter int   H_SYNC     = 44,
    parameter int   H_BP       = 148,
    parameter int   V_ACTIVE   = 1080,
    parameter int   V_FP       = 4,
    parameter int   V_SYNC     = 5,
    parameter int   V_BP       = 36,
    parameter logic HS_POL     = 1'b1,
    parameter logic VS_POL     = 1'b1,
    parameter int   COLOR_W    = 8,
    parameter int   CHECK_LOG2 = 5
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          en_i,
    input  logic [1:0]                    mode_i,
    output logic                          hsync_o,
    output logic                          vsync_o,
    output logic                          de_o,
    output logic [3*COLOR_W-1:0]          data_o,
    output logic [$clog2(H_ACTIVE)-1:0]   x_o,
    output logic [$clog2(V_ACTIVE)-1:0]   y_o,
    output logic                          frame_start_o
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int XW      = $clog2(H_ACTIVE);
    localparam int YW      = $clog2(V_ACTIVE);
    localparam int DW      = 3 * COLOR_W;

    localparam logic [HW-1:0] H_ACT_C = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG  = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END  = HW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT_C = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG  = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END  = VW'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);

    localparam logic [XW-1:0] BAR_W_C = XW'(H_ACTIVE / 8);
    // Single-bit masks that pick coordinate bit CHECK_LOG2; a mask of zero
    // (square larger than the raster) simply yields a constant colour.
    localparam logic [XW-1:0] X_CHK   = XW'(1 << CHECK_LOG2);
    localparam logic [YW-1:0] Y_CHK   = YW'(1 << CHECK_LOG2);

`ifdef VTG_BORDER_EN
    localparam logic [XW-1:0] X_LAST  = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(V_ACTIVE - 1);
`endif

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [HW-1:0]      h_cnt;
    logic [VW-1:0]      v_cnt;
    logic [1:0]         mode_q;
    logic [1:0]         mode_eff;

    logic               h_last;
    logic               v_last;
    logic               frame_origin;
    logic               active;
    logic               in_hsync;
    logic               in_vsync;
    logic [XW-1:0]      x_cur;
    logic [YW-1:0]      y_cur;

    logic [2:0]         bar_idx;
    logic [2:0]         bar_rgb;
    logic [COLOR_W-1:0] grad;
    logic               chk;
    logic [DW-1:0]      pix;

    logic               hs_nxt;
    logic               vs_nxt;
    logic               de_nxt;
    logic [DW-1:0]      data_nxt;
    logic [XW-1:0]      x_nxt;
    logic [YW-1:0]      y_nxt;
    logic               fs_nxt;

    assign h_last       = (h_cnt == H_LAST);
    assign v_last       = (v_cnt == V_LAST);
    assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
    assign active       = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
    assign in_hsync     = (h_cnt >= HS_BEG) && (h_cnt <= HS_END);
    // v_cnt only moves when h_cnt wraps, so vsync edges land on h_cnt = 0.
    assign in_vsync     = (v_cnt >= VS_BEG) && (v_cnt <= VS_END);
    assign x_cur        = h_cnt[XW-1:0];
    assign y_cur        = v_cnt[YW-1:0];

    // Pixel (0,0) has to use the mode being latched on this very cycle,
    // otherwise the first pixel of a frame would show the previous mode.
    assign mode_eff     = frame_origin ? mode_i : mode_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // RUN->STOP never halts the counters; STOP waits for the final counter
    // state of the frame so the sink always sees whole frames.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (en_i) state_nxt = RUN;
            RUN:  if (!en_i) state_nxt = STOP;
            STOP: begin
                if (en_i) begin
                    state_nxt = RUN;
                end else if (h_last && v_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Counters are held at zero while idle, so the IDLE->RUN edge leaves
    // them at (0,0) ready for the first pixel.
    always_ff @(posedge clk_i) begin
        if (rst_i || state == IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + VW'(1);
        end else begin
            h_cnt <= h_cnt + HW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q <= 2'd0;
        end else if (frame_origin) begin
            mode_q <= mode_i;
        end
    end

    assign bar_idx = 3'(x_cur / BAR_W_C);
    assign grad    = COLOR_W'(x_cur);
    assign chk     = (|(x_cur & X_CHK)) ^ (|(y_cur & Y_CHK));

    always_comb begin
        bar_rgb = 3'b000;
        case (bar_idx)
            3'd0:    bar_rgb = 3'b111;
            3'd1:    bar_rgb = 3'b110;
            3'd2:    bar_rgb = 3'b011;
            3'd3:    bar_rgb = 3'b010;
            3'd4:    bar_rgb = 3'b101;
            3'd5:    bar_rgb = 3'b100;
            3'd6:    bar_rgb = 3'b001;
            default: bar_rgb = 3'b000;
        endcase
    end

    always_comb begin
        pix = '0;
        case (mode_eff)
            2'd1:    pix = {{COLOR_W{bar_rgb[2]}}, {COLOR_W{bar_rgb[1]}}, {COLOR_W{bar_rgb[0]}}};
            2'd2:    pix = {grad, grad, grad};
            2'd3:    pix = chk ? {DW{1'b1}} : {DW{1'b0}};
            default: pix = '0;
        endcase
`ifdef VTG_BORDER_EN
        if (x_cur == '0 || x_cur == X_LAST || y_cur == '0 || y_cur == Y_LAST) begin
            pix = {DW{1'b1}};
        end
`endif
    end

    // Idle values are the defaults; they are overridden only while the
    // raster is running (RUN or STOP).
    always_comb begin
        hs_nxt   = ~HS_POL;
        vs_nxt   = ~VS_POL;
        de_nxt   = 1'b0;
        data_nxt = '0;
        x_nxt    = '0;
        y_nxt    = '0;
        fs_nxt   = 1'b0;
        if (state != IDLE) begin
            hs_nxt = in_hsync ? HS_POL : ~HS_POL;
            vs_nxt = in_vsync ? VS_POL : ~VS_POL;
            de_nxt = active;
            fs_nxt = active && frame_origin;
            if (active) begin
                data_nxt = pix;
                x_nxt    = x_cur;
                y_nxt    = y_cur;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hsync_o       <= ~HS_POL;
            vsync_o       <= ~VS_POL;
            de_o          <= 1'b0;
            data_o        <= '0;
            x_o           <= '0;
            y_o           <= '0;
            frame_start_o <= 1'b0;
        end else begin
            hsync_o       <= hs_nxt;
            vsync_o       <= vs_nxt;
            de_o          <= de_nxt;
            data_o        <= data_nxt;
            x_o           <= x_nxt;
            y_o           <= y_nxt;
            frame_start_o <= fs_nxt;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// -----------------------------------------------------------------------------
// tb_video_timing_gen
//
// Bench for video_timing_gen on a small 24x8 raster (16x4 active). For every
// clock the bench pushes the output vector it expects from the next edge onto
// a queue, then pops it after the edge and compares it with the DUT outputs.
// Expected vectors come from the raster position the bench itself tracks and
// from the pattern rules; a few pixels are also checked against constants.
// Honours VTG_BORDER_EN when the bench is built with it.
// -----------------------------------------------------------------------------
module tb_video_timing_gen;

    localparam int H_TOT = 24;
    localparam int FRAME = 192;

    localparam logic [23:0] BAR_COLOR [8] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

`ifdef VTG_BORDER_EN
    localparam logic [23:0] EDGE_PIX = 24'hFFFFFF;
`else
    localparam logic [23:0] EDGE_PIX = 24'h000000;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        en_i;
    logic [1:0]  mode_i;
    logic        hsync_o;
    logic        vsync_o;
    logic        de_o;
    logic [23:0] data_o;
    logic [3:0]  x_o;
    logic [1:0]  y_o;
    logic        frame_start_o;

    logic [33:0] dut_vec;
    logic [33:0] exp_q [$];

    int checks     = 0;
    int failures   = 0;
    int out_pos    = -1;
    int frame_mode = 0;
    int cyc        = 0;
    int last_fs    = -1;

    video_timing_gen #(
        .H_ACTIVE   (16),
        .H_FP       (2),
        .H_SYNC     (3),
        .H_BP       (3),
        .V_ACTIVE   (4),
        .V_FP       (1),
        .V_SYNC     (2),
        .V_BP       (1),
        .HS_POL     (1'b1),
        .VS_POL     (1'b1),
        .COLOR_W    (8),
        .CHECK_LOG2 (1)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .en_i          (en_i),
        .mode_i        (mode_i),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .de_o          (de_o),
        .data_o        (data_o),
        .x_o           (x_o),
        .y_o           (y_o),
        .frame_start_o (frame_start_o)
    );

    always #5 clk_i = ~clk_i;

    assign dut_vec = {hsync_o, vsync_o, de_o, data_o, x_o, y_o, frame_start_o};

    // Expected output vector for raster position pos (-1 = idle).
    function automatic logic [33:0] model(input int pos, input int mode);
        logic        hs, vs, de, fs;
        logic [23:0] d;
        logic [3:0]  xv;
        logic [1:0]  yv;
        int          h, v;
        hs = 1'b0; vs = 1'b0; de = 1'b0; fs = 1'b0;
        d = 24'h0; xv = 4'd0; yv = 2'd0;
        if (pos >= 0) begin
            h  = pos % H_TOT;
            v  = pos / H_TOT;
            hs = (h >= 18 && h <= 20);
            vs = (v >= 5 && v <= 6);
            de = (h < 16 && v < 4);
            fs = (pos == 0);
            if (de) begin
                xv = 4'(h);
                yv = 2'(v);
                case (mode)
                    1:       d = BAR_COLOR[h / 2];
                    2:       d = {3{8'(h)}};
                    3:       d = (((h / 2) % 2) != ((v / 2) % 2)) ? 24'hFFFFFF : 24'h0;
                    default: d = 24'h0;
                endcase
`ifdef VTG_BORDER_EN
                if (h == 0 || h == 15 || v == 0 || v == 3) d = 24'hFFFFFF;
`endif
            end
        end
        return {hs, vs, de, d, xv, yv, fs};
    endfunction

    // Raster position after one edge, given the position that edge shows.
    function automatic int next_pos(input int cur, input logic en);
        if (cur < 0)                  return en ? 0 : -1;
        if (cur == FRAME - 1 && !en)  return -1;
        return (cur + 1) % FRAME;
    endfunction

    task automatic push_expect();
        if (out_pos == 0) frame_mode = int'(mode_i);
        exp_q.push_back(model(out_pos, frame_mode));
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        logic [33:0] want;
        for (int i = 0; i < 5; i++) begin
            if (i == 3) rst_i = 1'b0;
            push_expect();
            tick();
            want = exp_q.pop_front();
            checks++;
            if (dut_vec !== want) begin
                failures++;
                $display("[TB] FAIL reset cyc=%0d got=%h want=%h", i, dut_vec, want);
            end
        end
    endtask

    task automatic test_start_latency();
        logic [33:0] want;
        mode_i = 2'd1;
        en_i   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push_expect();
            tick();
            want = exp_q.pop_front();
            checks++;
            if (dut_vec !== want) begin
                failures++;
                $display("[TB] FAIL start_edge%0d got=%h want=%h", i, dut_vec, want);
            end
            out_pos = next_pos(out_pos, en_i);
        end
        checks++;
        if ({de_o, frame_start_o, x_o, y_o} !== {1'b1, 1'b1, 4'd0, 2'd0}) begin
            failures++;
            $display("[TB] FAIL start_first_pixel got=%b want=%b",
                     {de_o, frame_start_o, x_o, y_o}, {1'b1, 1'b1, 4'd0, 2'd0});
        end
        last_fs = cyc;
    endtask

    task automatic test_free_run();
        logic [33:0] want;
        int cur;
        int de_cnt = -1;
        for (int i = 0; i < 2 * FRAME; i++) begin
            cur = out_pos;
            push_expect();
            tick();
            want = exp_q.pop_front();
            checks++;
            if (dut_vec !== want) begin
                failures++;
                $display("[TB] FAIL free_run pos=%0d got=%h want=%h", cur, dut_vec, want);
            end
            if (frame_start_o === 1'b1) begin
                checks++;
                if (cyc - last_fs != FRAME) begin
                    failures++;
                    $display("[TB] FAIL fs_period got=%0d want=%0d", cyc - last_fs, FRAME);
                end
                if (de_cnt >= 0) begin
                    checks++;
                    if (de_cnt != 64) begin
                        failures++;
                        $display("[TB] FAIL de_per_frame got=%0d want=64", de_cnt);
                    end
                end
                last_fs = cyc;
                de_cnt  = 0;
            end
            if (de_cnt >= 0 && de_o === 1'b1) de_cnt++;
            if (cur == H_TOT + 0 || cur == H_TOT + 2 || cur == H_TOT + 15) begin
                want[23:0] = (cur == H_TOT + 0) ? 24'hFFFFFF :
                             (cur == H_TOT + 2) ? 24'hFFFF00 : EDGE_PIX;
                checks++;
                if (data_o !== want[23:0]) begin
                    failures++;
                    $display("[TB] FAIL bar_colour pos=%0d got=%h want=%h", cur, data_o, want[23:0]);
                end
            end
            out_pos = next_pos(cur, en_i);
        end
    endtask

    task automatic test_stop_resume();
        logic [33:0] want;
        int cur;
        for (int i = 0; i < 200; i++) begin
            en_i = !(out_pos >= 50 && out_pos < 62);
            cur  = out_pos;
            push_expect();
            tick();
            want = exp_q.pop_front();
            checks++;
            if (dut_vec !== want) begin
                failures++;
                $display("[TB] FAIL stop_resume pos=%0d got=%h want=%h", cur, dut_vec, want);
            end
            if (frame_start_o === 1'b1) begin
                checks++;
                if (cyc - last_fs != FRAME) begin
                    failures++;
                    $display("[TB] FAIL resume_fs_period got=%0d want=%0d", cyc - last_fs, FRAME);
                end
                last_fs = cyc;
            end
            out_pos = next_pos(cur, en_i);
        end
    endtask

    task automatic test_stop_end();
        logic [33:0] want;
        int cur;
        for (int i = 0; i < 240; i++) begin
            if (out_pos == 100) en_i = 1'b0;
            cur = out_pos;
            push_expect();
            tick();
            want = exp_q.pop_front();
            checks++;
            if (dut_vec !== want) begin
                failures++;
                $display("[TB] FAIL stop_end pos=%0d got=%h want=%h", cur, dut_vec, want);
            end
            out_pos = next_pos(cur, en_i);
        end
    endtask

    task automatic test_mode_latch();
        logic [33:0] want;
        logic [23:0] pix_want;
        int cur;
        int frame_no = 0;
        mode_i = 2'd2;
        en_i   = 1'b1;
        for (int i = 0; i < 1 + FRAME + 40; i++) begin
            if (out_pos == 0) frame_no++;
            if (frame_no == 1 && out_pos == H_TOT + 5) mode_i = 2'd3;
            cur = out_pos;
            push_expect();
            tick();
            want = exp_q.pop_front();
            checks++;
            if (dut_vec !== want) begin
                failures++;
                $display("[TB] FAIL mode_latch f=%0d pos=%0d got=%h want=%h", frame_no, cur, dut_vec, want);
            end
            if ((frame_no == 1 && cur == H_TOT + 7) || (frame_no == 2 && (cur == 0 || cur == 2))) begin
                pix_want = (frame_no == 1) ? 24'h070707 : (cur == 2) ? 24'hFFFFFF : EDGE_PIX;
                checks++;
                if (data_o !== pix_want) begin
                    failures++;
                    $display("[TB] FAIL latch_pixel f=%0d pos=%0d got=%h want=%h", frame_no, cur, data_o, pix_want);
                end
            end
            out_pos = next_pos(cur, en_i);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [33:0] want;
        int cur;
        int rst_left = -1;
        for (int i = 0; i < 40; i++) begin
            if (out_pos == 2 * H_TOT + 10) begin
                rst_i    = 1'b1;
                rst_left = 2;
                out_pos  = -1;
            end else if (rst_left == 0) begin
                rst_i    = 1'b0;
                en_i     = 1'b0;
                rst_left = -1;
            end
            cur = out_pos;
            push_expect();
            tick();
            want = exp_q.pop_front();
            checks++;
            if (dut_vec !== want) begin
                failures++;
                $display("[TB] FAIL reset_mid pos=%0d got=%h want=%h", cur, dut_vec, want);
            end
            if (rst_left > 0) rst_left--;
            if (out_pos >= 0) out_pos = (out_pos + 1) % FRAME;
        end
    endtask

    task automatic test_border_mode0();
        logic [33:0] want;
        logic [23:0] pix_want;
        int cur;
        mode_i = 2'd0;
        en_i   = 1'b1;
        for (int i = 0; i < 1 + FRAME + 10; i++) begin
            if (out_pos == 100) en_i = 1'b0;
            cur = out_pos;
            push_expect();
            tick();
            want = exp_q.pop_front();
            checks++;
            if (dut_vec !== want) begin
                failures++;
                $display("[TB] FAIL border_run pos=%0d got=%h want=%h", cur, dut_vec, want);
            end
            if (cur == 0 || cur == 2 * H_TOT + 15 || cur == 3 * H_TOT + 7 || cur == H_TOT + 5) begin
                pix_want = (cur == H_TOT + 5) ? 24'h000000 : EDGE_PIX;
                checks++;
                if (data_o !== pix_want) begin
                    failures++;
                    $display("[TB] FAIL border_pixel pos=%0d got=%h want=%h", cur, data_o, pix_want);
                end
            end
            out_pos = next_pos(cur, en_i);
        end
    endtask

    initial begin
        rst_i  = 1'b1;
        en_i   = 1'b0;
        mode_i = 2'd0;
        test_reset();
        test_start_latency();
        test_free_run();
        test_stop_resume();
        test_stop_end();
        test_mode_latch();
        test_reset_mid_frame();
        test_border_mode0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
